// File: rtl/sender_fifo_serializer.sv
// sender_fifo_serializer: word FIFO that feeds a byte-wide downstream sender.
// Ports: CLK/reset/clear, data+start enqueue, sender_ready in; output_data/valid, full/empty/count/overflow out.
module sender_fifo_serializer #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 32,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit EDGE_START = 1'b1
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [8*WORD_BYTES-1:0]   data,
  input  logic                      start,
  input  logic                      sender_ready,
  output logic [7:0]                output_data,
  output logic                      valid,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int W  = 8*WORD_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [IW-1:0] idx;
  logic [IW-1:0] sel;
  logic [W-1:0]  head_word;
  logic          start_q;
  logic          req;
  logic          wr;
  logic          drop;
  logic          xfer;
  logic          last;
  logic          pop;

  assign req   = EDGE_START ? (start && !start_q) : start;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign valid = !empty;

  // Full is judged before any same-cycle pop, so a write
  // into a full FIFO is dropped even if the head leaves.
  assign wr    = req && !full;
  assign drop  = req && full;
  assign xfer  = valid && sender_ready;
  assign last  = (idx == IW'(WORD_BYTES-1));
  assign pop   = xfer && last;

  assign sel       = MSB_FIRST ? (IW'(WORD_BYTES-1) - idx) : idx;
  assign head_word = mem[head];

  // Masked when empty so unwritten entries never reach the port.
  always_comb begin
    output_data = 8'h00;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (valid && sel == IW'(b)) begin
        output_data = head_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      idx      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      start_q <= start;
      if (clear) begin
        head     <= '0;
        tail     <= '0;
        idx      <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr) begin
          tail <= tail + AW'(1);
        end
        if (drop) begin
          overflow <= 1'b1;
        end
        if (xfer) begin
          idx <= last ? '0 : idx + IW'(1);
        end
        if (pop) begin
          head <= head + AW'(1);
        end
        case ({wr, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr && !reset && !clear) begin
      mem[tail] <= data;
    end
  end

endmodule

// File: tb/tb_sender_fifo_serializer.sv
// tb_sender_fifo_serializer: directed bench over four parameter sets
// sharing one stimulus bus; each task checks the instance it targets.
module tb_sender_fifo_serializer;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        sender_ready = 1'b0;
  logic [31:0] data = '0;

  logic [7:0] od0, od1, od2, od3;
  logic       v0, v1, v2, v3;
  logic       f0, f1, f2, f3;
  logic       e0, e1, e2, e3;
  logic       ov0, ov1, ov2, ov3;
  logic [5:0] c0;
  logic [2:0] c1, c2;
  logic [1:0] c3;

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  // defaults: 4 bytes, depth 32, MSB first, edge start
  sender_fifo_serializer u_d0 (
    .CLK(CLK), .reset(reset), .clear(clear), .data(data),
    .start(start), .sender_ready(sender_ready),
    .output_data(od0), .valid(v0), .full(f0), .empty(e0),
    .count(c0), .overflow(ov0));

  // LSB first, depth 4, edge start
  sender_fifo_serializer #(.DEPTH(4), .MSB_FIRST(1'b0)) u_d1 (
    .CLK(CLK), .reset(reset), .clear(clear), .data(data),
    .start(start), .sender_ready(sender_ready),
    .output_data(od1), .valid(v1), .full(f1), .empty(e1),
    .count(c1), .overflow(ov1));

  // MSB first, depth 4, level start
  sender_fifo_serializer #(.DEPTH(4), .EDGE_START(1'b0)) u_d2 (
    .CLK(CLK), .reset(reset), .clear(clear), .data(data),
    .start(start), .sender_ready(sender_ready),
    .output_data(od2), .valid(v2), .full(f2), .empty(e2),
    .count(c2), .overflow(ov2));

  // plain byte FIFO, depth 2
  sender_fifo_serializer #(.WORD_BYTES(1), .DEPTH(2)) u_d3 (
    .CLK(CLK), .reset(reset), .clear(clear), .data(data[7:0]),
    .start(start), .sender_ready(sender_ready),
    .output_data(od3), .valid(v3), .full(f3), .empty(e3),
    .count(c3), .overflow(ov3));

  function automatic logic [31:0] word_of(input int k);
    logic [7:0] b;
    b = 8'(16*k);
    return {b + 8'd1, b + 8'd2, b + 8'd3, b + 8'd4};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    clear = 1'b0;
    sender_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] w);
    data = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (v0 !== 1'b0) $display("FAIL rst_valid got %0b want 0", v0); else passed++;
    checks++; if (c0 !== 6'd0) $display("FAIL rst_count got %0d want 0", c0); else passed++;
    checks++; if (e0 !== 1'b1) $display("FAIL rst_empty got %0b want 1", e0); else passed++;
    checks++; if (f0 !== 1'b0) $display("FAIL rst_full got %0b want 0", f0); else passed++;
    checks++; if (od0 !== 8'h00) $display("FAIL rst_data got %h want 00", od0); else passed++;
    checks++; if (ov0 !== 1'b0) $display("FAIL rst_ovf got %0b want 0", ov0); else passed++;
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_reset();
    data = 32'hA1B2C3D4;
    start = 1'b1;
    sender_ready = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (c0 !== 6'd1) $display("FAIL msb_count got %0d want 1", c0); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (v0 !== 1'b1 || od0 !== exp_b[i])
        $display("FAIL msb_byte%0d got %b/%h want 1/%h", i, v0, od0, exp_b[i]);
      else passed++;
      tick();
    end
    checks++; if (v0 !== 1'b0) $display("FAIL msb_end_valid got %0b want 0", v0); else passed++;
    checks++; if (c0 !== 6'd0) $display("FAIL msb_end_count got %0d want 0", c0); else passed++;
  endtask

  task automatic test_lsb_toggle();
    logic [7:0] exp_b [4];
    int n;
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    do_reset();
    data = 32'hA1B2C3D4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sender_ready = (k % 2 == 0);
      n = (k + 1) / 2;
      checks++;
      if (n < 4) begin
        if (v1 !== 1'b1 || od1 !== exp_b[n])
          $display("FAIL lsb_cyc%0d got %b/%h want 1/%h", k, v1, od1, exp_b[n]);
        else passed++;
      end else begin
        if (v1 !== 1'b0) $display("FAIL lsb_cyc%0d valid got %0b want 0", k, v1);
        else passed++;
      end
      tick();
    end
    checks++; if (c1 !== 3'd0) $display("FAIL lsb_end_count got %0d want 0", c1); else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] tw;
    do_reset();
    for (int i = 0; i < 5; i++) pulse(word_of(i));
    checks++; if (f1 !== 1'b1) $display("FAIL ovf_full got %0b want 1", f1); else passed++;
    checks++; if (c1 !== 3'd4) $display("FAIL ovf_count got %0d want 4", c1); else passed++;
    checks++; if (ov1 !== 1'b1) $display("FAIL ovf_flag got %0b want 1", ov1); else passed++;
    checks++; if (c2 !== 3'd4 || ov2 !== 1'b1) $display("FAIL ovf_lvl got %0d/%0b want 4/1", c2, ov2); else passed++;
    sender_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      tw = word_of(n / 4);
      checks++;
      if (od2 !== tw[31-8*(n%4) -: 8])
        $display("FAIL ovf_msb%0d got %h want %h", n, od2, tw[31-8*(n%4) -: 8]);
      else passed++;
      checks++;
      if (od1 !== tw[8*(n%4) +: 8])
        $display("FAIL ovf_lsb%0d got %h want %h", n, od1, tw[8*(n%4) +: 8]);
      else passed++;
      tick();
    end
    checks++; if (v1 !== 1'b0 || v2 !== 1'b0) $display("FAIL ovf_drained got %b%b want 00", v1, v2); else passed++;
  endtask

  task automatic test_edge_level();
    do_reset();
    data = word_of(7);
    start = 1'b1;
    repeat (10) tick();
    start = 1'b0;
    tick();
    checks++; if (c0 !== 6'd1) $display("FAIL edge_count got %0d want 1", c0); else passed++;
    checks++; if (ov0 !== 1'b0) $display("FAIL edge_ovf got %0b want 0", ov0); else passed++;
    checks++; if (c1 !== 3'd1) $display("FAIL edge4_count got %0d want 1", c1); else passed++;
    checks++; if (c2 !== 3'd4) $display("FAIL level_count got %0d want 4", c2); else passed++;
    checks++; if (f2 !== 1'b1 || ov2 !== 1'b1) $display("FAIL level_flags got %b%b want 11", f2, ov2); else passed++;
  endtask

  task automatic test_wrap();
    int ecount;
    bit wr_e;
    bit pop_e;
    logic [31:0] tw;
    do_reset();
    sender_ready = 1'b1;
    ecount = 0;
    for (int e = 0; e < 50; e++) begin
      wr_e = (e <= 2) || (e >= 4 && e <= 36 && e % 4 == 0);
      pop_e = (e >= 4 && e <= 48 && e % 4 == 0);
      start = wr_e;
      data = word_of((e <= 2) ? e : e / 4 + 2);
      tick();
      ecount += int'(wr_e) - int'(pop_e);
      checks++;
      if (c2 !== 3'(ecount) || c2 > 3'd4)
        $display("FAIL wrap_count%0d got %0d want %0d", e, c2, ecount);
      else passed++;
      if (e <= 47) begin
        tw = word_of(e / 4);
        checks++;
        if (v2 !== 1'b1 || od2 !== tw[31-8*(e%4) -: 8])
          $display("FAIL wrap_byte%0d got %b/%h want 1/%h", e, v2, od2, tw[31-8*(e%4) -: 8]);
        else passed++;
      end else begin
        checks++;
        if (v2 !== 1'b0) $display("FAIL wrap_tail%0d valid got %0b want 0", e, v2);
        else passed++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    sender_ready = 1'b1;
    data = 32'hA1B2C3D4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++; if (od0 !== 8'hC3) $display("FAIL mid_pre got %h want c3", od0); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (v0 !== 1'b0 || c0 !== 6'd0) $display("FAIL mid_rst got %b/%0d want 0/0", v0, c0); else passed++;
    checks++; if (od0 !== 8'h00) $display("FAIL mid_rst_data got %h want 00", od0); else passed++;
    data = 32'h11223344;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (v0 !== 1'b1 || od0 !== exp_b[i])
        $display("FAIL mid_new%0d got %b/%h want 1/%h", i, v0, od0, exp_b[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 5; i++) pulse(word_of(i));
    checks++; if (ov1 !== 1'b1) $display("FAIL clr_pre_ovf got %0b want 1", ov1); else passed++;
    clear = 1'b1;
    start = 1'b1;
    sender_ready = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (c1 !== 3'd0 || ov1 !== 1'b0) $display("FAIL clr_d1 got %0d/%0b want 0/0", c1, ov1); else passed++;
    checks++; if (c0 !== 6'd0 || v0 !== 1'b0) $display("FAIL clr_d0 got %0d/%0b want 0/0", c0, v0); else passed++;
    tick();
    start = 1'b0;
    checks++; if (c0 !== 6'd0) $display("FAIL clr_startq got %0d want 0", c0); else passed++;
    checks++; if (c2 !== 3'd1) $display("FAIL clr_level got %0d want 1", c2); else passed++;
  endtask

  task automatic test_byte_fifo();
    do_reset();
    pulse(32'h0000005A);
    pulse(32'h0000006B);
    pulse(32'h0000007C);
    checks++; if (f3 !== 1'b1 || c3 !== 2'd2) $display("FAIL wb1_full got %b/%0d want 1/2", f3, c3); else passed++;
    checks++; if (ov3 !== 1'b1) $display("FAIL wb1_ovf got %0b want 1", ov3); else passed++;
    sender_ready = 1'b1;
    checks++; if (od3 !== 8'h5A) $display("FAIL wb1_b0 got %h want 5a", od3); else passed++;
    tick();
    checks++; if (od3 !== 8'h6B) $display("FAIL wb1_b1 got %h want 6b", od3); else passed++;
    tick();
    checks++; if (v3 !== 1'b0 || e3 !== 1'b1) $display("FAIL wb1_end got %b%b want 01", v3, e3); else passed++;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_toggle();
    test_overflow();
    test_edge_level();
    test_wrap();
    test_reset_mid_word();
    test_clear();
    test_byte_fifo();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
